// File: rtl/ad_sample_multich.sv
// Multichannel ADC capture: offset-binary to two's complement, 2^AVG_LOG2 decimation,
// frame packing and a FWFT frame FIFO with drop accounting and burst done signalling.
module ad_sample_multich #(
    parameter int NUM_CH     = 2,
    parameter int ADC_W      = 12,
    parameter int OUT_W      = 16,
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          ad_clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          mode,
    input  logic                          start,
    input  logic [15:0]                   burst_len,
    input  logic [NUM_CH*ADC_W-1:0]       ad_in,
    output logic [NUM_CH*OUT_W-1:0]       m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt,
    input  logic                          ovf_clr
);
    localparam int AW = ADC_W + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int FW = NUM_CH * OUT_W;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [NUM_CH*ADC_W-1:0] ad_q;
    logic                    s0_vld;
    logic [CW-1:0]           cnt;
    logic [15:0]             frames_left;
    logic                    mode_q;
    logic signed [ADC_W-1:0] conv    [NUM_CH];
    logic signed [AW-1:0]    acc     [NUM_CH];
    logic signed [AW-1:0]    acc_nxt [NUM_CH];
    logic signed [ADC_W-1:0] avg     [NUM_CH];
    logic                    acc_done, acc_final;
    logic [FW-1:0]           frame_q, frame_nxt;
    logic                    frame_vld, frame_final;
    logic                    take_sample, frame_complete, last_frame, idle_zero;
    logic [FW-1:0]           mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [LW-1:0]           level;
    logic                    push, pop, full, drop;

    assign take_sample    = (state == RUN) && s0_vld;
    assign frame_complete = take_sample && (cnt == CNT_LAST);
    // Only a burst that is still enabled ends through DRAIN with a done pulse.
    assign last_frame     = frame_complete && mode_q && (frames_left == 16'd1) && en;

    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        idle_zero = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    if (!mode) begin
                        state_nxt = RUN;
                    end else if (start) begin
                        if (burst_len == 16'd0) idle_zero = 1'b1;
                        else                    state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (!en)             state_nxt = IDLE;
                else if (last_frame) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (frame_vld && frame_final) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            mode_q      <= 1'b0;
            frames_left <= '0;
        end else if (state == IDLE && state_nxt == RUN) begin
            mode_q      <= mode;
            frames_left <= burst_len;
        end else if (frame_complete && mode_q) begin
            frames_left <= frames_left - 16'd1;
        end
    end

    always_comb begin
        frame_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            conv[c]    = {~ad_q[c*ADC_W+ADC_W-1], ad_q[c*ADC_W +: ADC_W-1]};
            acc_nxt[c] = (cnt == '0) ? AW'(conv[c]) : acc[c] + AW'(conv[c]);
            avg[c]     = ADC_W'(acc[c] >>> AVG_LOG2);
            frame_nxt[c*OUT_W +: OUT_W] = OUT_W'(avg[c]);
        end
    end

    // S0 register, S1 accumulate, S2 frame register ahead of the FIFO write.
    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            ad_q        <= '0;
            s0_vld      <= 1'b0;
            cnt         <= '0;
            acc_done    <= 1'b0;
            acc_final   <= 1'b0;
            frame_q     <= '0;
            frame_vld   <= 1'b0;
            frame_final <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        end else begin
            ad_q      <= ad_in;
            s0_vld    <= (state == RUN);
            acc_done  <= frame_complete;
            acc_final <= last_frame;
            if (state != RUN) cnt <= '0;
            else if (take_sample) cnt <= frame_complete ? '0 : cnt + 1'b1;
            if (take_sample)
                for (int c = 0; c < NUM_CH; c++) acc[c] <= acc_nxt[c];
            frame_vld   <= acc_done;
            frame_final <= acc_final;
            if (acc_done) frame_q <= frame_nxt;
        end
    end

    assign full = (level == LW'(FIFO_DEPTH));
    assign pop  = (level != '0) && m_ready;
    assign push = frame_vld && (!full || pop);
    assign drop = frame_vld && full && !pop;

    always_ff @(posedge ad_clk) begin
        if (push) mem[wr_ptr] <= frame_q;
    end

    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            done     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
            if (ovf_clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
            done <= idle_zero || (frame_vld && frame_final);
        end
    end

    assign m_valid    = (level != '0);
    assign m_data     = m_valid ? mem[rd_ptr] : '0;
    assign fifo_level = level;
    assign busy       = (state != IDLE);
endmodule

// File: tb/tb_ad_sample_multich.sv
// Randomized scoreboard bench for ad_sample_multich: a driver pushes expected frames computed
// from offset-binary arithmetic; a negedge monitor pops and compares on every handshake.
module tb_ad_sample_multich;
    logic        ad_clk = 1'b0;
    logic        rst = 1'b1, en = 1'b0, mode = 1'b0, start = 1'b0;
    logic        m_ready = 1'b0, ovf_clr = 1'b0;
    logic [15:0] burst_len = '0;
    logic [23:0] ad_in = '0;
    logic [31:0] m_data;
    logic        m_valid, busy, done, overflow;
    logic [4:0]  fifo_level;
    logic [15:0] drop_cnt;

    int          tests = 0, fails = 0, pops = 0, done_cnt = 0;
    logic [31:0] exp_q[$];
    bit          rnd_rdy = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_data;

    ad_sample_multich dut (
        .ad_clk(ad_clk), .rst(rst), .en(en), .mode(mode), .start(start),
        .burst_len(burst_len), .ad_in(ad_in), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .fifo_level(fifo_level), .busy(busy), .done(done),
        .overflow(overflow), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
    );

    always #5 ad_clk = ~ad_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Floor of sum/4, as a 16-bit two's complement channel value.
    function automatic logic [15:0] model_avg(input int sum);
        int a;
        a = (sum >= 0) ? sum / 4 : -((-sum + 3) / 4);
        return 16'(a);
    endfunction

    task automatic step();
        @(posedge ad_clk);
        #1;
        if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_frame(input logic [11:0] a [4], input logic [11:0] b [4], input bit push);
        int s0 = 0, s1 = 0;
        for (int k = 0; k < 4; k++) begin
            ad_in = {b[k], a[k]};
            s0 += int'(a[k]) - 2048;
            s1 += int'(b[k]) - 2048;
            step();
        end
        if (push) exp_q.push_back({model_avg(s1), model_avg(s0)});
    endtask

    task automatic drive_fixed(input logic [11:0] c0, input logic [11:0] c1, input bit push);
        logic [11:0] a [4];
        logic [11:0] b [4];
        for (int k = 0; k < 4; k++) begin a[k] = c0; b[k] = c1; end
        drive_frame(a, b, push);
    endtask

    task automatic drive_rand(input bit push);
        logic [11:0] a [4];
        logic [11:0] b [4];
        for (int k = 0; k < 4; k++) begin
            a[k] = 12'($urandom_range(0, 4095));
            b[k] = 12'($urandom_range(0, 4095));
        end
        drive_frame(a, b, push);
    endtask

    task automatic start_cont();
        en = 1'b1; mode = 1'b0;
        step();
    endtask

    task automatic stop();
        en = 1'b0;
        step();
    endtask

    task automatic drain();
        repeat (5) step();
        for (int i = 0; i < 200 && fifo_level != 0; i++) step();
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge ad_clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid && m_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame: got %h expected none", m_data);
                end else begin
                    check("frame", m_data, exp_q.pop_front());
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        logic [11:0] a [4];
        logic [11:0] b [4];
        int base_done, base_pops;

        #1;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_data", m_data, 32'd0);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Full-scale conversion and mid-scale zero.
        m_ready = 1'b1;
        start_cont();
        check("cont_busy", 32'(busy), 32'd1);
        drive_fixed(12'hFFF, 12'h000, 1'b1);
        drive_fixed(12'hFFF, 12'h000, 1'b1);
        drive_fixed(12'h800, 12'h000, 1'b1);
        stop();
        drain();

        // Floor behaviour and first-valid latency.
        start_cont();
        a = '{12'h801, 12'h801, 12'h801, 12'h800};
        b = '{12'h7FF, 12'h7FF, 12'h7FF, 12'h800};
        drive_frame(a, b, 1'b1);
        stop();
        step();
        check("lat_before", 32'(m_valid), 32'd0);
        step();
        check("lat_at", 32'(m_valid), 32'd1);
        start_cont();
        drive_frame(b, a, 1'b1);
        stop();
        drain();

        // Counted burst with an ignored second start.
        base_done = done_cnt; base_pops = pops;
        en = 1'b1; mode = 1'b1; start = 1'b1; burst_len = 16'd5;
        step();
        start = 1'b0;
        for (int f = 0; f < 5; f++) begin
            start = (f == 2);
            mode  = (f != 3);
            drive_rand(1'b1);
        end
        start = 1'b0;
        for (int i = 0; i < 20 && done_cnt == base_done; i++) step();
        repeat (6) step();
        check("burst_done", 32'(done_cnt - base_done), 32'd1);
        check("burst_busy", 32'(busy), 32'd0);
        check("burst_frames", 32'(pops - base_pops), 32'd5);
        en = 1'b0; mode = 1'b0;
        drain();

        // Zero-length burst.
        en = 1'b1; mode = 1'b1; start = 1'b1; burst_len = 16'd0;
        step();
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        start = 1'b0; en = 1'b0; mode = 1'b0;
        step();
        check("zero_done_low", 32'(done), 32'd0);
        repeat (6) step();
        check("zero_level", 32'(fifo_level), 32'd0);

        // Overflow, pop-at-full acceptance, clear priority.
        m_ready = 1'b0;
        start_cont();
        for (int f = 0; f < 16; f++) drive_rand(1'b1);
        stop();
        start_cont();
        drive_rand(1'b0);
        stop();
        repeat (3) step();
        check("full_level", 32'(fifo_level), 32'd16);
        check("ovf_set", 32'(overflow), 32'd1);
        check("drop_one", 32'(drop_cnt), 32'd1);
        start_cont();
        drive_rand(1'b1);
        stop();
        step();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        step();
        check("pop_full_level", 32'(fifo_level), 32'd16);
        check("pop_full_drop", 32'(drop_cnt), 32'd1);
        start_cont();
        drive_rand(1'b0);
        stop();
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_drop", 32'(drop_cnt), 32'd0);
        m_ready = 1'b1;
        drain();

        // Random backpressure.
        rnd_rdy = 1'b1;
        start_cont();
        for (int f = 0; f < 8; f++) drive_rand(1'b1);
        stop();
        drain();
        rnd_rdy = 1'b0;
        m_ready = 1'b1;
        step();

        // Reset mid-burst with frames buffered.
        m_ready = 1'b0;
        base_done = done_cnt;
        en = 1'b1; mode = 1'b1; start = 1'b1; burst_len = 16'd20;
        step();
        start = 1'b0;
        for (int f = 0; f < 8; f++) drive_rand(1'b1);
        repeat (3) step();
        check("pre_rst_level", 32'(fifo_level), 32'd8);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        en = 1'b0; mode = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        m_ready = 1'b1;
        start_cont();
        drive_rand(1'b1);
        drive_rand(1'b1);
        stop();
        drain();
        check("rst_no_done", 32'(done_cnt - base_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
